lcd_spi_write: RTL

//  Byte-level SPI transmitter for the 12864 LCD (ST7565-class controller). Sits directly downstream
//  of the draw controller: accepts one 10-bit tagged word per SPI_Start_Sig/SPI_Done_Sig handshake
//  and drives CS/A0/SCLK/MOSI. Bits[9:8] of the word select command (00), display data (01) or no-op (1x).

---
 rtl/lcd_spi_write_if.sv | 21 ++
 rtl/lcd_spi_write.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/lcd_spi_write_if.sv
// Handshake and LCD pin bundle between the draw controller and the SPI byte writer.
interface lcd_spi_write_if;
  logic       SPI_Start_Sig;
  logic [9:0] SPI_Data;
  logic       SPI_Done_Sig;
  logic       Busy;
  logic       LCD_CS;
  logic       LCD_A0;
  logic       LCD_SCLK;
  logic       LCD_MOSI;

  modport master (
    output SPI_Start_Sig, SPI_Data,
    input  SPI_Done_Sig, Busy, LCD_CS, LCD_A0, LCD_SCLK, LCD_MOSI
  );

  modport slave (
    input  SPI_Start_Sig, SPI_Data,
    output SPI_Done_Sig, Busy, LCD_CS, LCD_A0, LCD_SCLK, LCD_MOSI
  );
endinterface

// File: rtl/lcd_spi_write.sv
// Byte-level SPI transmitter for an ST7565-class LCD: one tagged 10-bit word per
// Start/Done handshake, driving CS/A0/SCLK/MOSI with all outputs registered.
module lcd_spi_write #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2
) (
  input  logic              CLK,
  input  logic              RST,
  lcd_spi_write_if.slave    bus
);

  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CS_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int unsigned CNT_W  = (CS_MAX > 1) ? $clog2(CS_MAX) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
  localparam bit               NO_HOLD    = (CS_HOLD == 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [6:0]       shift_q, shift_d;
  logic             cs_q, cs_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             a0_q, a0_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  // State and output registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b1;
      mosi_q  <= 1'b0;
      a0_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      a0_q    <= a0_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and next-output logic; outputs are set for the state being entered
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    a0_d    = a0_q;
    done_d  = 1'b0;
    busy_d  = busy_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.SPI_Start_Sig) begin
          busy_d = 1'b1;
          if (bus.SPI_Data[9]) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_SETUP;
            cs_d    = 1'b0;
            a0_d    = bus.SPI_Data[8];
            cnt_d   = SETUP_LAST;
          end
        end
      end

      S_SETUP: begin
        // Late sample lets a one-cycle-latency source settle before the byte is taken
        if (cnt_q == '0) begin
          state_d = S_SHIFT;
          a0_d    = bus.SPI_Data[8];
          mosi_d  = bus.SPI_Data[7];
          shift_d = bus.SPI_Data[6:0];
          sclk_d  = 1'b0;
          div_d   = DIV_LAST;
          bit_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_SHIFT: begin
        if (div_q != '0) begin
          div_d = div_q - DIV_W'(1);
        end else if (!sclk_q) begin
          sclk_d = 1'b1;
          div_d  = DIV_LAST;
        end else if (bit_q == 3'd7) begin
          bit_d = 3'd0;
          if (NO_HOLD) begin
            state_d = S_DONE;
            cs_d    = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d = S_HOLD;
            cnt_d   = HOLD_LAST;
          end
        end else begin
          bit_d   = bit_q + 3'd1;
          sclk_d  = 1'b0;
          mosi_d  = shift_q[6];
          shift_d = {shift_q[5:0], 1'b0};
          div_d   = DIV_LAST;
        end
      end

      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          cs_d    = 1'b1;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_DONE: begin
        // Start is deliberately ignored here; upstream is still releasing it
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        cs_d    = 1'b1;
        sclk_d  = 1'b1;
      end
    endcase
  end

  assign bus.SPI_Done_Sig = done_q;
  assign bus.Busy         = busy_q;
  assign bus.LCD_CS       = cs_q;
  assign bus.LCD_A0       = a0_q;
  assign bus.LCD_SCLK     = sclk_q;
  assign bus.LCD_MOSI     = mosi_q;

endmodule
